// File: rtl/pll_reset_sequencer_if.sv
// Status and control signals between the PLL reset sequencer and its environment.
// The sequencer is the master; the PLL/board side is the slave.
interface pll_reset_sequencer_if;
  logic       pll_locked_i;
  logic       soft_reset_req_i;
  logic       pll_rst_o;
  logic       sys_rst_n_o;
  logic       ready_o;
  logic       fail_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] lock_loss_cnt_o;
  logic [2:0] state_o;

  modport master (
    input  pll_locked_i, soft_reset_req_i,
    output pll_rst_o, sys_rst_n_o, ready_o, fail_o,
           retry_cnt_o, lock_loss_cnt_o, state_o
  );

  modport slave (
    output pll_locked_i, soft_reset_req_i,
    input  pll_rst_o, sys_rst_n_o, ready_o, fail_o,
           retry_cnt_o, lock_loss_cnt_o, state_o
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, waits for a stable lock, then releases the system reset.
// Retries on lock timeout, latches FAIL after MAX_RETRIES, re-sequences on lock loss.
module pll_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 125000,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned MAX_RETRIES      = 3,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  pll_reset_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam logic [31:0] RST_LAST     = 32'(RST_PULSE_CYC - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [31:0] STABLE_LAST  = 32'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t                 state, state_nxt;
  logic [31:0]            cnt, cnt_nxt;
  logic [3:0]             retry, retry_nxt;
  logic [7:0]             loss, loss_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;
  logic                   pll_rst_q, sys_rst_n_q, ready_q, fail_q;

  assign lock_s = sync[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry;
    loss_nxt  = loss;
    if (bus.soft_reset_req_i) begin
      state_nxt = PLL_RST;
      retry_nxt = '0;
    end else begin
      case (state)
        PLL_RST: begin
          cnt_nxt = cnt + 32'd1;
          if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          cnt_nxt = cnt + 32'd1;
          if (lock_s) begin
            state_nxt = STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry == RETRY_LIMIT) begin
              state_nxt = FAIL;
            end else begin
              retry_nxt = retry + 4'd1;
              state_nxt = PLL_RST;
            end
          end
        end
        STABLE: begin
          cnt_nxt = cnt + 32'd1;
          if (!lock_s)                 state_nxt = WAIT_LOCK;
          else if (cnt == STABLE_LAST) state_nxt = RUN;
        end
        RUN: begin
          if (!lock_s) begin
            state_nxt = PLL_RST;
            retry_nxt = '0;
            if (loss != '1) loss_nxt = loss + 8'd1;
          end
        end
        FAIL:    ;
        default: state_nxt = PLL_RST;
      endcase
    end
    // soft reset while already in PLL_RST must still restart the pulse
    if (state_nxt != state || bus.soft_reset_req_i) cnt_nxt = '0;
  end

  // Outputs are registered from the next state so they align with state_o.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state       <= PLL_RST;
      cnt         <= '0;
      retry       <= '0;
      loss        <= '0;
      sync        <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      sync        <= {sync[SYNC_STAGES-2:0], bus.pll_locked_i};
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry       <= retry_nxt;
      loss        <= loss_nxt;
      pll_rst_q   <= (state_nxt == PLL_RST) || (state_nxt == FAIL);
      sys_rst_n_q <= (state_nxt == RUN);
      ready_q     <= (state_nxt == RUN);
      fail_q      <= (state_nxt == FAIL);
    end
  end

  assign bus.pll_rst_o       = pll_rst_q;
  assign bus.sys_rst_n_o     = sys_rst_n_q;
  assign bus.ready_o         = ready_q;
  assign bus.fail_o          = fail_q;
  assign bus.retry_cnt_o     = retry;
  assign bus.lock_loss_cnt_o = loss;
  assign bus.state_o         = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed test-plan scenarios followed by random lock/soft-reset/reset traffic,
// all checked every cycle against a timestamp-based reference model.
module tb_pll_reset_sequencer;
  localparam int unsigned RST_PULSE_CYC    = 4;
  localparam int unsigned LOCK_TIMEOUT_CYC = 20;
  localparam int unsigned LOCK_STABLE_CYC  = 8;
  localparam int unsigned MAX_RETRIES      = 2;
  localparam int unsigned SYNC_STAGES      = 2;

  logic refclk = 1'b0;
  logic rst_n;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .RST_PULSE_CYC   (RST_PULSE_CYC),
    .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
    .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
    .MAX_RETRIES     (MAX_RETRIES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 refclk = ~refclk;

  int   checks = 0;
  int   fails  = 0;
  int   edge_n = 0;
  int   t0     = 0;
  bit   valid  = 1'b0;
  logic lock_in = 1'b0, soft_in = 1'b0, rstn_in = 1'b0;

  // Model: phase number, edge index at which the phase was entered, and a
  // queue holding the last SYNC_STAGES lock inputs.
  int m_phase = 0, m_entered = 0, m_retry = 0, m_loss = 0;
  bit m_hist[$];

  function automatic int cyc();
    return edge_n - t0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc(), got, exp);
    end
  endtask

  task automatic enter(input int p);
    m_phase   = p;
    m_entered = edge_n + 1;
  endtask

  task automatic model_edge();
    bit ls;
    int e;
    if (!rstn_in) begin
      enter(0);
      m_retry = 0;
      m_loss  = 0;
      m_hist  = {};
      for (int unsigned i = 0; i < SYNC_STAGES; i++) m_hist.push_back(1'b0);
    end else begin
      ls = m_hist.pop_front();
      m_hist.push_back(lock_in);
      e = edge_n - m_entered;
      if (soft_in) begin
        enter(0);
        m_retry = 0;
      end else begin
        case (m_phase)
          0: if (e == int'(RST_PULSE_CYC) - 1) enter(1);
          1: begin
            if (ls) enter(2);
            else if (e == int'(LOCK_TIMEOUT_CYC) - 1) begin
              if (m_retry == int'(MAX_RETRIES)) enter(4);
              else begin
                m_retry++;
                enter(0);
              end
            end
          end
          2: begin
            if (!ls) enter(1);
            else if (e == int'(LOCK_STABLE_CYC) - 1) enter(3);
          end
          3: if (!ls) begin
            if (m_loss < 255) m_loss++;
            m_retry = 0;
            enter(0);
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic step();
    @(negedge refclk);
    if (valid) begin
      chk("state", 32'(bus.state_o), 32'(m_phase));
      chk("outs", {28'd0, bus.pll_rst_o, bus.sys_rst_n_o, bus.ready_o, bus.fail_o},
          {28'd0, (m_phase == 0) || (m_phase == 4), m_phase == 3, m_phase == 3, m_phase == 4});
      chk("retry", 32'(bus.retry_cnt_o), 32'(m_retry));
      chk("loss", 32'(bus.lock_loss_cnt_o), 32'(m_loss));
    end
    rst_n                = rstn_in;
    bus.pll_locked_i     = lock_in;
    bus.soft_reset_req_i = soft_in;
    model_edge();
    @(posedge refclk);
    edge_n++;
    if (!rstn_in) valid = 1'b1;
  endtask

  task automatic step_to(input int c);
    while (cyc() < c) step();
  endtask

  task automatic do_reset();
    rstn_in = 1'b0;
    lock_in = 1'b0;
    soft_in = 1'b0;
    step();
    step();
    rstn_in = 1'b1;
    t0 = edge_n;
  endtask

  // Expects reset to have just been released (cycle 0 is next).
  task automatic bringup();
    lock_in = 1'b0;
    step_to(3);  #1 chk("s1_rst_hi_c3", 32'(bus.pll_rst_o), 32'd1);
    step_to(4);  #1 chk("s1_rst_lo_c4", 32'(bus.pll_rst_o), 32'd0);
                    chk("s1_wait_c4", 32'(bus.state_o), 32'd1);
    step_to(6);  lock_in = 1'b1;
    step_to(8);  #1 chk("s1_wait_c8", 32'(bus.state_o), 32'd1);
    step_to(9);  #1 chk("s1_stable_c9", 32'(bus.state_o), 32'd2);
    step_to(16); #1 chk("s1_notready_c16", 32'(bus.ready_o), 32'd0);
    step_to(17); #1 chk("s1_sysrst_c17", 32'(bus.sys_rst_n_o), 32'd1);
                    chk("s1_ready_c17", 32'(bus.ready_o), 32'd1);
                    chk("s1_retry", 32'(bus.retry_cnt_o), 32'd0);
  endtask

  initial begin
    // Scenario 1: clean bring-up
    do_reset();
    #1 chk("reset_state", 32'(bus.state_o), 32'd0);
       chk("reset_outs", {28'd0, bus.pll_rst_o, bus.sys_rst_n_o, bus.ready_o, bus.fail_o}, 32'h8);
    bringup();

    // Scenario 4: lock loss in RUN, then saturation of the loss counter
    step_to(30); lock_in = 1'b0;
    step_to(32); #1 chk("s4_sysrst_c32", 32'(bus.sys_rst_n_o), 32'd1);
    step_to(33); #1 chk("s4_sysrst_c33", 32'(bus.sys_rst_n_o), 32'd0);
                    chk("s4_pllrst_c33", 32'(bus.pll_rst_o), 32'd1);
                    chk("s4_loss1", 32'(bus.lock_loss_cnt_o), 32'd1);
    step_to(40); lock_in = 1'b1;
    step_to(50); #1 chk("s4_notready_c50", 32'(bus.ready_o), 32'd0);
    step_to(51); #1 chk("s4_ready_c51", 32'(bus.ready_o), 32'd1);
    repeat (300) begin
      lock_in = 1'b0;
      repeat (3) step();
      lock_in = 1'b1;
      repeat (20) step();
    end
    #1 chk("s4_loss_sat", 32'(bus.lock_loss_cnt_o), 32'd255);
       chk("s4_ready_again", 32'(bus.ready_o), 32'd1);

    // Scenario 5b: soft reset coincident with rst_n low
    rstn_in = 1'b0;
    soft_in = 1'b1;
    step();
    rstn_in = 1'b1;
    soft_in = 1'b0;
    t0 = edge_n;
    #1 chk("s5b_state", 32'(bus.state_o), 32'd0);
       chk("s5b_loss", 32'(bus.lock_loss_cnt_o), 32'd0);
       chk("s5b_pllrst", 32'(bus.pll_rst_o), 32'd1);
       chk("s5b_sysrst", 32'(bus.sys_rst_n_o), 32'd0);

    // Scenario 6: one-cycle reset while in RUN, after one lock loss
    bringup();
    step_to(30); lock_in = 1'b0;
    step_to(34); lock_in = 1'b1;
    step_to(60); #1 chk("s6_ready_pre", 32'(bus.ready_o), 32'd1);
                    chk("s6_loss_pre", 32'(bus.lock_loss_cnt_o), 32'd1);
    rstn_in = 1'b0;
    step();
    rstn_in = 1'b1;
    t0 = edge_n;
    #1 chk("s6_sysrst", 32'(bus.sys_rst_n_o), 32'd0);
       chk("s6_pllrst", 32'(bus.pll_rst_o), 32'd1);
       chk("s6_loss_clr", 32'(bus.lock_loss_cnt_o), 32'd0);
       chk("s6_state", 32'(bus.state_o), 32'd0);
    bringup();

    // Scenario 3: lock drops during STABLE
    do_reset();
    step_to(6);  lock_in = 1'b1;
    step_to(12); lock_in = 1'b0;
    step_to(14); lock_in = 1'b1;
                 #1 chk("s3_stable_c14", 32'(bus.state_o), 32'd2);
    step_to(15); #1 chk("s3_wait_c15", 32'(bus.state_o), 32'd1);
    step_to(24); #1 chk("s3_notready_c24", 32'(bus.ready_o), 32'd0);
    step_to(25); #1 chk("s3_ready_c25", 32'(bus.ready_o), 32'd1);
                    chk("s3_retry", 32'(bus.retry_cnt_o), 32'd0);

    // Scenario 2: never lock
    do_reset();
    #1 chk("s2_pllrst_c0", 32'(bus.pll_rst_o), 32'd1);
    step_to(23); #1 chk("s2_pllrst_c23", 32'(bus.pll_rst_o), 32'd0);
    step_to(24); #1 chk("s2_pllrst_c24", 32'(bus.pll_rst_o), 32'd1);
                    chk("s2_retry_c24", 32'(bus.retry_cnt_o), 32'd1);
    step_to(28); #1 chk("s2_pllrst_c28", 32'(bus.pll_rst_o), 32'd0);
    step_to(48); #1 chk("s2_pllrst_c48", 32'(bus.pll_rst_o), 32'd1);
    step_to(71); #1 chk("s2_wait_c71", 32'(bus.state_o), 32'd1);
    step_to(72); #1 chk("s2_fail_c72", 32'(bus.fail_o), 32'd1);
                    chk("s2_state_c72", 32'(bus.state_o), 32'd4);
                    chk("s2_retry_c72", 32'(bus.retry_cnt_o), 32'd2);
                    chk("s2_sysrst_c72", 32'(bus.sys_rst_n_o), 32'd0);

    // Scenario 5a: soft reset out of FAIL
    step_to(80); soft_in = 1'b1;
    step();
    soft_in = 1'b0;
    #1 chk("s5a_state", 32'(bus.state_o), 32'd0);
       chk("s5a_fail", 32'(bus.fail_o), 32'd0);
       chk("s5a_retry", 32'(bus.retry_cnt_o), 32'd0);
    step_to(84); #1 chk("s5a_pulse_c84", 32'(bus.pll_rst_o), 32'd1);
    step_to(85); #1 chk("s5a_wait_c85", 32'(bus.state_o), 32'd1);

    // Random lock activity with occasional soft and hard resets
    do_reset();
    begin
      int run = 0;
      for (int i = 0; i < 3000; i++) begin
        if (run == 0) begin
          lock_in = ($urandom_range(0, 3) != 0);
          run = lock_in ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
        end
        run--;
        soft_in = ($urandom_range(0, 63) == 0);
        rstn_in = ($urandom_range(0, 199) != 0);
        step();
      end
    end
    rstn_in = 1'b1;
    soft_in = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
